array_11_port_ctrl: RTL and testbench
=====================================

Name: array_11_port_ctrl

Overview:
- Initiator-side controller for the 16x28 single-port, 14-bit-mask-granular synchronous array (RW0 port: addr/en/wmode/wmask/wdata/rdata).
- Converts a valid/ready request stream into array port cycles and returns read data on a valid/ready response stream through a 3-entry response FIFO.
- After reset, zero-fills the whole array before it accepts any request.
- Sits between core-side request logic and the array macro.

Parameters:
- DEPTH, 16, number of array words
- ADDR_W, 4, address width (log2 DEPTH)
- DATA_W, 28, word width
- SEGS, 2, write-mask segments; segment width = DATA_W/SEGS = 14
- RESP_DEPTH, 3, response FIFO entries (fixed; gives full read throughput at 2-cycle latency)

Ports:
- clock  in  1  clock for the controller and the array
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&&ready
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_W  word address
- req_mask  in  SEGS  per-14-bit-segment write enable; ignored for reads
- req_data  in  DATA_W  write data
- resp_valid  out  1  read response valid
- resp_ready  in  1  response consumer ready
- resp_data  out  DATA_W  read data
- init_done  out  1  high once zero-fill is complete
- mem_addr  out  ADDR_W  to array RW0_addr
- mem_en  out  1  to array RW0_en
- mem_wmode  out  1  to array RW0_wmode
- mem_wmask  out  SEGS  to array RW0_wmask
- mem_wdata  out  DATA_W  to array RW0_wdata
- mem_rdata  in  DATA_W  from array RW0_rdata; valid the cycle after a read-enable cycle

Behaviour:
- Reset (async assert, sync release):
  - state=INIT, init counter=0, FIFO empty, pend=0.
  - Registered outputs: init_done=0, resp_valid=0, resp_data=0.
  - req_ready=0.
- INIT state:
  - Each cycle: mem_en=1, mem_wmode=1, mem_wmask=all ones, mem_wdata=0, mem_addr=counter.
  - Counter increments every cycle. The cycle that writes DEPTH-1 transitions to RUN.
  - init_done rises on the first RUN cycle, exactly DEPTH=16 cycles after reset release.
  - req_ready=0 throughout INIT; requests are held off, not dropped.
- RUN state:
  - req_ready = (occ + pend) < RESP_DEPTH.
    - occ = FIFO occupancy; pend = 1 if a read was issued in the previous cycle.
    - req_ready is registered-state only; there is no combinational path from resp_ready or req_valid.
  - fire = req_valid && req_ready.
  - On fire, same cycle (combinational): mem_en=1, mem_wmode=req_write, mem_addr=req_addr.
    - Write: mem_wmask=req_mask, mem_wdata=req_data.
    - Read: mem_wmask=0, mem_wdata=0.
  - No fire: mem_en=0 and all other mem_* outputs 0.
  - Write with req_mask=0: still issues an enabled write cycle; the array is unchanged. Writes produce no response.
  - Read fired in cycle N: pend=1 in N+1; mem_rdata is captured into the FIFO at the end of N+1; resp_valid is high from N+2. Read-to-response latency is 2 cycles.
  - Write to address A in cycle N followed by read of A in N+1 returns the new data; the array port is naturally ordered.
  - FIFO: in-order, push and pop in the same cycle allowed, occ unchanged. resp_data = FIFO head; holds stable while resp_valid && !resp_ready.
  - Credit rule guarantees a push never meets a full FIFO. Overflow is a design error; the bench asserts it never occurs.
- State never returns to INIT except through reset_n.
- reset_n asserted mid-INIT or mid-RUN:
  - FIFO contents and any in-flight read are discarded.
  - Zero-fill restarts from address 0 after release.

Test Plan:
- Init sweep: release reset -> mem_en=1/mem_wmode=1/mem_wmask=2'b11/mem_wdata=0 for addr 0..15 on 16 consecutive cycles; init_done=1 and req_ready=1 on cycle 16; a read of addr 9 returns 0.
- Write/read: write addr 5 data 28'hABCDEF1 mask 2'b11, next cycle read 5 -> resp_valid two cycles after the read fire with resp_data=28'hABCDEF1.
- Masked write: write addr 3 data 28'hFFFFFFF mask 2'b11, then data 0 mask 2'b01, read 3 -> 28'hFFFC000; repeat with mask 2'b00 -> value unchanged.
- Backpressure: resp_ready=0, issue reads of addrs 0,1,2 back-to-back -> req_ready=0 after the third fire, FIFO holds 3 entries in order, no overflow; raise resp_ready -> 3 responses on consecutive cycles, then req_ready returns to 1.
- Streaming: resp_ready=1, read addrs 0..15 on 16 consecutive cycles -> req_ready never drops, 16 responses in address order, one per cycle, starting 2 cycles after the first fire.
- Reset mid-operation: assert reset_n during INIT at counter=7, and again in RUN with 2 responses queued -> outputs return to reset values immediately; after release, the full 16-cycle zero-fill repeats and no stale responses appear.

Source files
------------

// File: rtl/array_11_port_ctrl.sv
// array_11_port_ctrl: initiator-side controller for a 16x28 single-port array
// with a 14-bit write-mask granularity. It zero-fills the array after reset,
// then turns a request stream into array port cycles. Read data comes back
// through a 3-entry response FIFO.
//
// Handshake semantics (both streams): a transfer happens on a rising clock edge
// where valid && ready. A valid source holds its payload stable until that edge.
// req_ready and resp_valid come from registered state only. They never depend
// combinationally on req_valid or resp_ready.
module array_11_port_ctrl #(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 28,
  parameter int SEGS       = 2,
  parameter int RESP_DEPTH = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [SEGS-1:0]   req_mask,
  input  logic [DATA_W-1:0] req_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              init_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  output logic              mem_wmode,
  output logic [SEGS-1:0]   mem_wmask,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              o_dbg_state
);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_init_cnt;
  logic              r_init_done;
  logic              r_pend;
  logic              r_resp_valid;
  logic [1:0]        r_occ;
  logic [1:0]        w_occ_nxt;
  logic [1:0]        w_wr_idx;
  logic [DATA_W-1:0] r_fifo [RESP_DEPTH];
  logic [2:0]        w_credit_sum;
  logic              w_req_ready;
  logic              w_fire;
  logic              w_push;
  logic              w_pop;
  logic              w_init_last;

  // Credit: outstanding reads (queued + one in the array pipeline) must fit the FIFO.
  assign w_credit_sum = {1'b0, r_occ} + {2'b00, r_pend};
  assign w_req_ready  = (r_state == ST_RUN) && (w_credit_sum < 3'(RESP_DEPTH));
  assign w_fire       = req_valid && w_req_ready;
  assign w_push       = r_pend;
  assign w_pop        = (r_occ != 2'd0) && resp_ready;
  assign w_init_last  = (r_init_cnt == ADDR_W'(DEPTH - 1));
  // On a simultaneous pop, the FIFO shifts down first, so the new entry lands one slot lower.
  assign w_wr_idx     = w_pop ? (r_occ - 2'd1) : r_occ;

  assign req_ready   = w_req_ready;
  assign resp_valid  = r_resp_valid;
  assign resp_data   = r_fifo[0];
  assign init_done   = r_init_done;
  assign o_dbg_state = r_state;

  // FSM state register, zero-fill counter, init flag and read-pending flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_INIT;
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
      r_pend      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_fire && !req_write;
      if (r_state == ST_INIT) begin
        r_init_cnt <= r_init_cnt + 1'b1;
        if (w_init_last) r_init_done <= 1'b1;
      end
    end
  end

  // Next state and array port drive: the zero-fill sweep in INIT, request pass-through in RUN.
  always_comb begin
    w_state_nxt = r_state;
    mem_en      = 1'b0;
    mem_wmode   = 1'b0;
    mem_addr    = '0;
    mem_wmask   = '0;
    mem_wdata   = '0;
    case (r_state)
      ST_INIT: begin
        mem_en    = 1'b1;
        mem_wmode = 1'b1;
        mem_wmask = '1;
        mem_addr  = r_init_cnt;
        if (w_init_last) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_fire) begin
          mem_en    = 1'b1;
          mem_wmode = req_write;
          mem_addr  = req_addr;
          if (req_write) begin
            mem_wmask = req_mask;
            mem_wdata = req_data;
          end
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // FIFO occupancy after this cycle's push and pop.
  always_comb begin
    w_occ_nxt = r_occ;
    if (w_push && !w_pop)      w_occ_nxt = r_occ + 2'd1;
    else if (!w_push && w_pop) w_occ_nxt = r_occ - 2'd1;
  end

  // Response FIFO as a shift queue with the head in slot 0, so resp_data is a plain register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RESP_DEPTH; i++) r_fifo[i] <= '0;
      r_occ        <= 2'd0;
      r_resp_valid <= 1'b0;
    end else begin
      if (w_pop) begin
        for (int i = 0; i < RESP_DEPTH - 1; i++) r_fifo[i] <= r_fifo[i+1];
        r_fifo[RESP_DEPTH-1] <= '0;
      end
      if (w_push) r_fifo[w_wr_idx] <= mem_rdata;
      r_occ        <= w_occ_nxt;
      r_resp_valid <= (w_occ_nxt != 2'd0);
    end
  end

endmodule

// File: tb/tb_array_11_port_ctrl.sv
// Bench for array_11_port_ctrl: a behavioural array model, directed driver
// tasks, and a response monitor that checks against an expected-data queue.
module tb_array_11_port_ctrl;

  localparam int DW = 28;
  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [1:0]    req_mask = '0;
  logic [DW-1:0] req_data = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [DW-1:0] resp_data;
  logic          init_done;
  logic [AW-1:0] mem_addr;
  logic          mem_en;
  logic          mem_wmode;
  logic [1:0]    mem_wmask;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          dbg_state;

  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;
  int            outstanding = 0;
  logic [DW-1:0] exp_q[$];
  int            resp_cyc_q[$];
  logic [DW-1:0] mem_model [16];
  logic          scramble = 1'b1;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  int            fire_c [16];

  array_11_port_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_mask(req_mask), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .init_done(init_done),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_wmode(mem_wmode),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .o_dbg_state(dbg_state)
  );

  // Clock and reset block
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Array model: synchronous, 14-bit segment masks, read data valid the cycle after.
  // While scramble is set, its contents are filled with garbage so that zero-fill is observable.
  always @(posedge clock) begin
    if (scramble) begin
      for (int i = 0; i < 16; i++) mem_model[i] <= DW'($urandom);
    end else if (mem_en) begin
      if (mem_wmode) begin
        if (mem_wmask[0]) mem_model[mem_addr][13:0]  <= mem_wdata[13:0];
        if (mem_wmask[1]) mem_model[mem_addr][27:14] <= mem_wdata[27:14];
      end else begin
        mem_rdata <= mem_model[mem_addr];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: pops the expected queue on every response transfer.
  always @(negedge clock) begin
    if (!reset_n) begin
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(resp_valid), 64'd1);
        check("hold_data", 64'(resp_data), 64'(prev_data));
      end
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp actual=%0h required=no_response", resp_data);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          check("resp_data", 64'(resp_data), 64'(e));
        end
        resp_cyc_q.push_back(cyc);
        outstanding--;
      end
      if (req_valid && req_ready && !req_write) begin
        outstanding++;
        check("no_overflow", 64'(outstanding <= 3), 64'd1);
      end
      prev_stall = resp_valid && !resp_ready;
      prev_data  = resp_data;
    end
  end

  // Driver tasks: every task is entered and left just after a rising edge.
  task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [1:0] mask,
                       input logic [DW-1:0] data, output int fire_cyc);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_mask  = mask;
    req_data  = data;
    @(negedge clock);
    while (!req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("req_accept", 64'(req_ready), 64'd1);
    fire_cyc = cyc;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_mask  = '0;
    req_data  = '0;
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [1:0] mask);
    int f;
    issue(1'b1, addr, mask, data, f);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp, output int f);
    exp_q.push_back(exp);
    issue(1'b0, addr, 2'b00, '0, f);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    scramble = 1'b1;
    exp_q.delete();
    #1;
    check("rst_init_done", 64'(init_done), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_data", 64'(resp_data), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    repeat (2) @(posedge clock);
    scramble = 1'b0;
    #1;
    reset_n = 1'b1;
  endtask

  task automatic init_sweep();
    for (int i = 0; i < 16; i++) begin
      logic [AW-1:0] a;
      a = 4'(i);
      @(negedge clock);
      check("init_port", 64'({mem_en, mem_wmode, mem_wmask, mem_wdata, mem_addr}),
            64'({1'b1, 1'b1, 2'b11, 28'h0, a}));
      check("init_busy", 64'({init_done, req_ready}), 64'd0);
    end
    @(negedge clock);
    check("init_done_ready", 64'({init_done, req_ready, dbg_state}), 64'b111);
    check("run_idle_port", 64'(mem_en), 64'd0);
    @(posedge clock);
    #1;
  endtask

  // Directed stimulus sequence
  initial begin
    int f;
    do_reset();
    init_sweep();

    // Read of a zero-filled word.
    do_read(4'd9, 28'h0, f);
    idle(4);

    // A write followed directly by a read of the same word, with the 2-cycle latency checked.
    do_write(4'd5, 28'hABCDEF1, 2'b11);
    do_read(4'd5, 28'hABCDEF1, f);
    @(negedge clock);
    check("rd_lat_n1", 64'(resp_valid), 64'd0);
    @(negedge clock);
    check("rd_lat_n2", 64'({resp_valid, resp_data}), 64'({1'b1, 28'hABCDEF1}));
    idle(3);

    // Masked writes
    do_write(4'd3, 28'hFFFFFFF, 2'b11);
    do_write(4'd3, 28'h0000000, 2'b01);
    do_read(4'd3, 28'hFFFC000, f);
    idle(4);
    do_write(4'd3, 28'h0000000, 2'b00);
    do_read(4'd3, 28'hFFFC000, f);
    idle(4);

    // Backpressure: three reads fill the credits.
    do_write(4'd0, 28'h1111111, 2'b11);
    do_write(4'd1, 28'h2222222, 2'b11);
    do_write(4'd2, 28'h3333333, 2'b11);
    resp_ready = 1'b0;
    do_read(4'd0, 28'h1111111, f);
    do_read(4'd1, 28'h2222222, f);
    do_read(4'd2, 28'h3333333, f);
    @(negedge clock);
    check("bp_ready_low", 64'(req_ready), 64'd0);
    idle(3);
    @(negedge clock);
    check("bp_full_hold", 64'({req_ready, resp_valid, resp_data}), 64'({1'b0, 1'b1, 28'h1111111}));
    @(posedge clock);
    #1;
    resp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("bp_drain_valid", 64'(resp_valid), 64'd1);
    end
    @(negedge clock);
    check("bp_drained", 64'({resp_valid, req_ready}), 64'b01);
    @(posedge clock);
    #1;

    // Streaming: 16 back-to-back reads with the consumer always ready.
    for (int i = 0; i < 16; i++) begin
      logic [AW-1:0] a;
      a = 4'(i);
      do_write(a, {a, 20'hBEEF0, ~a}, 2'b11);
    end
    resp_cyc_q.delete();
    for (int i = 0; i < 16; i++) begin
      logic [AW-1:0] a;
      a = 4'(i);
      do_read(a, {a, 20'hBEEF0, ~a}, fire_c[i]);
    end
    idle(6);
    check("stream_count", 64'(resp_cyc_q.size()), 64'd16);
    for (int i = 0; i < 16; i++) begin
      check("stream_fire_cyc", 64'(fire_c[i]), 64'(fire_c[0] + i));
      if (i < resp_cyc_q.size())
        check("stream_resp_cyc", 64'(resp_cyc_q[i]), 64'(fire_c[0] + 2 + i));
    end

    // Reset asserted mid-INIT at counter 7.
    do_reset();
    repeat (7) @(posedge clock);
    @(negedge clock);
    check("mid_init_addr", 64'(mem_addr), 64'd7);
    do_reset();
    init_sweep();
    do_read(4'd5, 28'h0, f);
    idle(4);

    // Reset in RUN with two responses queued
    do_write(4'd4, 28'h1234567, 2'b11);
    resp_ready = 1'b0;
    do_read(4'd4, 28'h1234567, f);
    do_read(4'd4, 28'h1234567, f);
    idle(3);
    @(negedge clock);
    check("run_two_queued", 64'({resp_valid, resp_data}), 64'({1'b1, 28'h1234567}));
    do_reset();
    resp_ready = 1'b1;
    init_sweep();
    idle(5);
    @(negedge clock);
    check("no_stale_resp", 64'(resp_valid), 64'd0);
    @(posedge clock);
    #1;
    do_read(4'd4, 28'h0, f);
    idle(5);

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
